// File: rtl/gf2273_pkg.sv
// Shared constants and FSM encoding for the GF(2273) exponentiator.
// Holds the modulus, operand/product widths and the state enum.
package gf2273_pkg;

    localparam int Q      = 2273;
    localparam int Q_W    = 12;
    localparam int PROD_W = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQ_M,
        S_SQ_R,
        S_ML_M,
        S_ML_R,
        S_DONE
    } state_t;

endpackage

// File: rtl/barret_for_2273.sv
// Combinational Barrett reducer: dout_r = din_a mod 2273.
// Ports: din_a (23b product in), dout_r (12b remainder out).
module barret_for_2273
    import gf2273_pkg::*;
(
    input  logic [PROD_W-1:0] din_a,
    output logic [Q_W-1:0]    dout_r
);

    // m = floor(2^24 / 2273); the quotient estimate is at most one low,
    // so the remainder before correction is below 2*Q.
    localparam logic [35:0] M_BARRETT = 36'd7381;

    logic [11:0] w_q;
    logic [13:0] w_qq;
    logic [13:0] w_r0;
    logic [13:0] w_r1;

    assign w_q  = 12'(({13'b0, din_a} * M_BARRETT) >> 24);
    // Remainder fits 14 bits, so modulo-2^14 arithmetic is exact here.
    assign w_qq = 14'({2'b0, w_q} * 14'(Q));
    assign w_r0 = din_a[13:0] - w_qq;
    assign w_r1 = (w_r0 >= 14'(Q)) ? w_r0 - 14'(Q) : w_r0;
    assign dout_r = 12'((w_r1 >= 14'(Q)) ? w_r1 - 14'(Q) : w_r1);

endmodule

// File: rtl/modexp_2273.sv
// Left-to-right square-and-multiply: result = base^exp mod 2273.
// Ports: clk, rst (sync, active-high), start, base, exp -> busy, done, result.
module modexp_2273
    import gf2273_pkg::*;
#(
    parameter int EXP_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Q_W-1:0]   base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   result
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_t r_state;
    state_t w_next;

    logic [EXP_W-1:0]  r_e;
    logic [IDX_W-1:0]  r_idx;
    logic [Q_W-1:0]    r_acc;
    logic [Q_W-1:0]    r_b_red;
    logic [PROD_W-1:0] r_prod;
    logic [Q_W-1:0]    r_result;

    logic [Q_W-1:0]    w_dout;
    logic [Q_W-1:0]    w_op;
    logic [PROD_W-1:0] w_mul;
    logic              w_bit_end;

    barret_for_2273 u_red (
        .din_a  (r_prod),
        .dout_r (w_dout)
    );

    // Single multiplier; its second operand is b_red only in ML_M.
    assign w_op  = (r_state == S_ML_M) ? r_b_red : r_acc;
    assign w_mul = {11'b0, r_acc} * {11'b0, w_op};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_bit_end = 1'b0;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        unique case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: w_next = S_SQ_M;
            S_SQ_M: w_next = S_SQ_R;
            S_SQ_R: begin
                if (r_e[r_idx]) begin
                    w_next = S_ML_M;
                end else begin
                    w_bit_end = 1'b1;
                    w_next = (r_idx == '0) ? S_DONE : S_SQ_M;
                end
            end
            S_ML_M: w_next = S_ML_R;
            S_ML_R: begin
                w_bit_end = 1'b1;
                w_next = (r_idx == '0) ? S_DONE : S_SQ_M;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e      <= '0;
            r_idx    <= '0;
            r_acc    <= Q_W'(1);
            r_b_red  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_e    <= exp;
                        r_prod <= {11'b0, base};
                        r_acc  <= Q_W'(1);
                        r_idx  <= IDX_W'(EXP_W - 1);
                    end
                end
                S_LOAD: r_b_red <= w_dout;
                S_SQ_M: r_prod  <= w_mul;
                S_ML_M: r_prod  <= w_mul;
                S_SQ_R: r_acc   <= w_dout;
                S_ML_R: r_acc   <= w_dout;
                default: ;
            endcase
            // Last bit: the value going into acc is the final answer.
            if (w_bit_end) begin
                if (r_idx == '0) r_result <= w_dout;
                else             r_idx    <= r_idx - 1'b1;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_modexp_2273.sv
// Scoreboard bench for modexp_2273: directed cases plus random sweep
// against a repeated-multiplication reference model.
module tb_modexp_2273;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base = '0;
    logic [11:0] t_exp = '0;
    logic        busy;
    logic        done;
    logic [11:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndone = 0;

    typedef struct {
        logic [11:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];

    modexp_2273 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .base   (base),
        .exp    (t_exp),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_pow(int b, int e);
        longint r = 1;
        longint bb = longint'(b % 2273);
        for (int i = 0; i < e; i++) r = (r * bb) % 2273;
        return int'(r);
    endfunction

    function automatic int ref_lat(int e);
        return 1 + 2 * 12 + 2 * $countones(e[11:0]);
    endfunction

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            ndone++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d result=%0d", cyc, result);
            end else begin
                e = sb.pop_front();
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL result got=%0d want=%0d", result, e.res);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL latency done_edge=%0d want=%0d", cyc, e.due);
                end
            end
        end
    end

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Called at a negedge; accept happens on the next posedge.
    task automatic issue(int b, int e, int want);
        exp_t x;
        x.res = 12'(want);
        x.due = cyc + 1 + ref_lat(e);
        sb.push_back(x);
        base  = 12'(b);
        t_exp = 12'(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base  = 12'($urandom);
        t_exp = 12'($urandom);
    endtask

    // Returns at the negedge where done is high, or flags a timeout.
    task automatic wait_done();
        int n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done");
        end
    endtask

    task automatic run_op(int b, int e, int want, bit chk_busy);
        issue(b, e, want);
        if (chk_busy) chk("busy_after_accept", int'(busy), 1);
        wait_done();
        @(negedge clk);
        if (chk_busy) chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        int d0;
        int gap;
        int rb;
        int re;
        exp_t x;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        @(negedge clk);

        run_op(2, 11, 2048, 1);
        run_op(5, 2271, 1364, 1);
        run_op(3, 2272, 1, 1);
        run_op(2278, 1, 5, 1);
        run_op(4095, 1, 1822, 1);
        run_op(0, 0, 1, 1);
        run_op(0, 5, 0, 0);
        run_op(1234, 4095, ref_pow(1234, 4095), 0);

        // Starts during busy and in the DONE cycle are dropped.
        d0 = ndone;
        issue(2, 11, 2048);
        repeat (5) @(negedge clk);
        base = 12'd7; t_exp = 12'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        base = 12'd9; t_exp = 12'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done_start", int'(busy), 0);
        repeat (60) @(negedge clk);
        chk("single_done", ndone - d0, 1);

        // Reset sampled at edge 10 after accept aborts the run.
        d0 = ndone;
        issue(5, 2271, 1364);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_done", int'(done), 0);
        repeat (50) @(negedge clk);
        chk("abort_no_done", ndone - d0, 0);
        run_op(5, 2271, 1364, 1);

        for (int i = 0; i < 2000; i++) begin
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) @(negedge clk);
            rb = $urandom_range(0, 4095);
            re = $urandom_range(0, 4095);
            run_op(rb, re, ref_pow(rb, re), 0);
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            x = sb[0];
            $display("FAIL leftover_expect count=%0d want_res=%0d", sb.size(), x.res);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
